// File: rtl/bc_msg_egress.sv
// Broadcast-message egress queue: tags core stores that fall in the broadcast windows and queues them for the fabric.
// Optional BC_MSG_COALESCE_EN merges a store that hits the tail entry's word instead of queueing it again.
module bc_msg_egress #(
   parameter int          ADDR_WIDTH      = 25,
   parameter logic [31:0] BC_START_ADDR   = 32'h010FF030,
   parameter int          REGION_SIZE     = 4048,
   parameter int          REGION_COUNT    = 2,
   parameter int          REGION_ID_WIDTH = (REGION_COUNT > 1) ? $clog2(REGION_COUNT) : 1,
   parameter int          MSG_ADDR_WIDTH  = $clog2(REGION_SIZE) - 2,
   parameter int          MSG_WIDTH       = 32 + 4 + MSG_ADDR_WIDTH + REGION_ID_WIDTH,
   parameter int          FIFO_DEPTH      = 16,
   parameter int          AFULL_MARGIN    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          core_dmem_en,
   input  logic                          core_mem_wen,
   input  logic [3:0]                    core_mem_strb,
   input  logic [ADDR_WIDTH-1:0]         core_mem_addr,
   input  logic [31:0]                   core_mem_wr_data,
   output logic                          core_msg_ready,
   output logic [MSG_WIDTH-1:0]          bc_msg_out,
   output logic                          bc_msg_out_valid,
   input  logic                          bc_msg_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   drop_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int OFF_LSB = 36;

   logic [MSG_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_next, tail_idx;
   logic [LVL_W-1:0]     level, level_next;
   logic [32:0]          addr_ext, base;
   logic                 hit;
   logic [REGION_ID_WIDTH-1:0] hit_id;
   logic [MSG_ADDR_WIDTH-1:0]  hit_off;
   logic [MSG_WIDTH-1:0] new_msg, merged_msg, head_next;
   logic                 push_req, pop, merge, do_push, drop, full;

   assign addr_ext = 33'(core_mem_addr);

   // Window decode: regions are disjoint, so the first match is the only match.
   always_comb begin
      hit     = 1'b0;
      hit_id  = '0;
      hit_off = '0;
      base    = '0;
      for (int i = 0; i < REGION_COUNT; i++) begin
         base = 33'(BC_START_ADDR) + 33'(i) * 33'(REGION_SIZE);
         if (!hit && addr_ext >= base && addr_ext < base + 33'(REGION_SIZE)) begin
            hit     = 1'b1;
            hit_id  = REGION_ID_WIDTH'(i);
            hit_off = MSG_ADDR_WIDTH'((addr_ext - base) >> 2);
         end
      end
   end

   assign new_msg  = {hit_id, hit_off, core_mem_strb, core_mem_wr_data};
   assign push_req = core_dmem_en & core_mem_wen & hit;
   assign pop      = bc_msg_out_valid & bc_msg_out_ready;
   assign full     = (level == LVL_W'(FIFO_DEPTH));
   assign tail_idx = wr_ptr - PTR_W'(1);

`ifdef BC_MSG_COALESCE_EN
   logic [MSG_WIDTH-1:0] tail;
   assign tail = mem[tail_idx];
   // A single entry that is leaving this cycle cannot absorb the store.
   assign merge = push_req && (level != '0)
                  && (tail[MSG_WIDTH-1:OFF_LSB] == new_msg[MSG_WIDTH-1:OFF_LSB])
                  && !((level == LVL_W'(1)) && pop);

   always_comb begin
      merged_msg = tail;
      for (int b = 0; b < 4; b++) begin
         if (core_mem_strb[b]) merged_msg[8*b +: 8] = core_mem_wr_data[8*b +: 8];
      end
      merged_msg[35:32] = tail[35:32] | core_mem_strb;
   end
`else
   assign merge      = 1'b0;
   assign merged_msg = new_msg;
`endif

   assign do_push    = push_req & ~merge & (~full | pop);
   assign drop       = push_req & ~merge & full & ~pop;
   assign rd_next    = rd_ptr + PTR_W'(pop);
   assign level_next = level + LVL_W'(do_push) - LVL_W'(pop);

   // Head register is reloaded from the post-update queue so a write landing on the new head is seen at once.
   always_comb begin
      if (level_next == '0)
         head_next = '0;
      else if (do_push && (wr_ptr == rd_next))
         head_next = new_msg;
      else if (merge && (tail_idx == rd_next))
         head_next = merged_msg;
      else
         head_next = mem[rd_next];
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= new_msg;
      else if (merge)
         mem[tail_idx] <= merged_msg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         level            <= '0;
         bc_msg_out       <= '0;
         bc_msg_out_valid <= 1'b0;
         core_msg_ready   <= 1'b1;
         drop_count       <= '0;
      end else begin
         rd_ptr           <= rd_next;
         wr_ptr           <= wr_ptr + PTR_W'(do_push);
         level            <= level_next;
         bc_msg_out       <= head_next;
         bc_msg_out_valid <= (level_next != '0);
         core_msg_ready   <= (LVL_W'(FIFO_DEPTH) - level_next) > LVL_W'(AFULL_MARGIN);
         if (drop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
      end
   end

   assign fifo_level = level;

endmodule

// File: tb/tb_bc_msg_egress.sv
// Randomised and directed bench for bc_msg_egress against a queue-based reference model.
module tb_bc_msg_egress;
   localparam logic [31:0] START = 32'h010FF030;
   localparam int RS = 4048;
   localparam int RC = 2;
   localparam int DEPTH = 16;
   localparam int MARGIN = 2;

   typedef struct packed {
      logic [0:0]  id;
      logic [9:0]  off;
      logic [3:0]  strb;
      logic [31:0] data;
   } msg_t;

   logic        clk, rst_n, core_dmem_en, core_mem_wen, core_msg_ready;
   logic [3:0]  core_mem_strb;
   logic [24:0] core_mem_addr;
   logic [31:0] core_mem_wr_data;
   logic [46:0] bc_msg_out;
   logic        bc_msg_out_valid, bc_msg_out_ready;
   logic [4:0]  fifo_level;
   logic [15:0] drop_count;

   bc_msg_egress dut (
      .clk(clk), .rst_n(rst_n), .core_dmem_en(core_dmem_en), .core_mem_wen(core_mem_wen),
      .core_mem_strb(core_mem_strb), .core_mem_addr(core_mem_addr), .core_mem_wr_data(core_mem_wr_data),
      .core_msg_ready(core_msg_ready), .bc_msg_out(bc_msg_out), .bc_msg_out_valid(bc_msg_out_valid),
      .bc_msg_out_ready(bc_msg_out_ready), .fifo_level(fifo_level), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   msg_t q[$];
   int   drops;
   bit   rdy_m;
   int   vectors, miscompares;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic decode(input logic [24:0] a, input logic [3:0] s, input logic [31:0] d,
                         output bit hit, output msg_t m);
      longint delta;
      delta = longint'(a) - longint'(START);
      hit = (delta >= 0) && (delta < longint'(RC * RS));
      m.id   = hit ? 1'(delta / RS) : 1'b0;
      m.off  = hit ? 10'((delta % RS) / 4) : 10'd0;
      m.strb = s;
      m.data = d;
   endtask

   // One clock: drive, advance model from pre-edge state, compare after the edge.
   task automatic cycle(input bit rst, input bit en, input bit wen, input logic [3:0] s,
                        input logic [24:0] a, input logic [31:0] d, input bit rdy);
      bit   hit, pop, push, merge;
      msg_t m, t;
      rst_n = ~rst; core_dmem_en = en; core_mem_wen = wen; core_mem_strb = s;
      core_mem_addr = a; core_mem_wr_data = d; bc_msg_out_ready = rdy;
      decode(a, s, d, hit, m);
      pop   = (q.size() > 0) && rdy;
      push  = en && wen && hit;
      merge = 1'b0;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         drops = 0;
      end else begin
`ifdef BC_MSG_COALESCE_EN
         if (push && q.size() > 0 && q[q.size()-1].id == m.id && q[q.size()-1].off == m.off
             && !(q.size() == 1 && pop)) begin
            merge = 1'b1;
            t = q[q.size()-1];
            for (int b = 0; b < 4; b++) if (m.strb[b]) t.data[8*b +: 8] = m.data[8*b +: 8];
            t.strb = t.strb | m.strb;
            q[q.size()-1] = t;
         end
`endif
         if (pop) void'(q.pop_front());
         if (push && !merge) begin
            if (q.size() < DEPTH) q.push_back(m);
            else if (drops < 65535) drops++;
         end
      end
      rdy_m = (DEPTH - q.size()) > MARGIN;
      chk("valid", 64'(bc_msg_out_valid), 64'(q.size() != 0));
      chk("level", 64'(fifo_level), 64'(q.size()));
      chk("drop_count", 64'(drop_count), 64'(drops));
      chk("core_msg_ready", 64'(core_msg_ready), 64'(rdy_m));
      if (q.size() != 0) chk("bc_msg_out", 64'(bc_msg_out), 64'(q[0]));
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 25'd0, 32'd0, rdy);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit rdy);
      cycle(1'b0, 1'b1, 1'b1, s, 25'(a), d, rdy);
   endtask

   initial begin
      vectors = 0; miscompares = 0; drops = 0;
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 25'd0, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 25'd0, 32'd0, 1'b0);
      chk("reset_out", 64'(bc_msg_out), 64'd0);
      chk("reset_ready", 64'(core_msg_ready), 64'd1);

      // Single store emitted next cycle and popped.
      store(START + 32'd8, 32'hDEADBEEF, 4'hF, 1'b1);
      chk("t1_msg", 64'(bc_msg_out), 64'({1'b0, 10'd2, 4'hF, 32'hDEADBEEF}));
      chk("t1_valid", 64'(bc_msg_out_valid), 64'd1);
      idle(1'b1);
      chk("t1_level", 64'(fifo_level), 64'd0);

      // Region 1 tag, and a store just below region 0 ignored.
      store(START + RS + 32'd4, 32'h12345678, 4'hF, 1'b0);
      chk("t2_msg", 64'(bc_msg_out), 64'({1'b1, 10'd1, 4'hF, 32'h12345678}));
      store(START - 32'd4, 32'hCAFEF00D, 4'hF, 1'b0);
      chk("t2_below", 64'(fifo_level), 64'd1);
      idle(1'b1);

      // Fill to almost-full, then overflow.
      for (int i = 0; i < 14; i++) begin
         store(START + 32'(4 * i), 32'(i + 100), 4'hF, 1'b0);
         if (i == 12) chk("t3_ready13", 64'(core_msg_ready), 64'd1);
      end
      chk("t3_level14", 64'(fifo_level), 64'd14);
      chk("t3_ready14", 64'(core_msg_ready), 64'd0);
      for (int i = 14; i < 17; i++) store(START + 32'(4 * i), 32'(i + 100), 4'hF, 1'b0);
      chk("t3_level16", 64'(fifo_level), 64'd16);
      chk("t3_drop", 64'(drop_count), 64'd1);

      // Push and pop together while full.
      store(START + 32'd400, 32'h0BADCAFE, 4'hF, 1'b1);
      chk("t4_level", 64'(fifo_level), 64'd16);
      chk("t4_drop", 64'(drop_count), 64'd1);
      chk("t4_head", 64'(bc_msg_out), 64'({1'b0, 10'd1, 4'hF, 32'd101}));
      for (int i = 0; i < 17; i++) idle(1'b1);

      // Reset mid-operation.
      for (int i = 0; i < 5; i++) store(START + 32'(8 * i), 32'(i), 4'hF, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 25'd0, 32'd0, 1'b0);
      chk("t5_valid", 64'(bc_msg_out_valid), 64'd0);
      chk("t5_level", 64'(fifo_level), 64'd0);
      chk("t5_ready", 64'(core_msg_ready), 64'd1);
      store(START + RS, 32'h55AA55AA, 4'h3, 1'b0);
      chk("t5_msg", 64'(bc_msg_out), 64'({1'b1, 10'd0, 4'h3, 32'h55AA55AA}));
      chk("t5_level1", 64'(fifo_level), 64'd1);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 25'd0, 32'd0, 1'b0);

      // Two partial stores to one word.
      store(START + 32'h20, 32'h000000AA, 4'h1, 1'b0);
      store(START + 32'h20, 32'h0000BB00, 4'h2, 1'b0);
`ifdef BC_MSG_COALESCE_EN
      chk("t6_level", 64'(fifo_level), 64'd1);
      chk("t6_msg", 64'(bc_msg_out), 64'({1'b0, 10'd8, 4'h3, 32'h0000BBAA}));
`else
      chk("t6_level", 64'(fifo_level), 64'd2);
      chk("t6_msg", 64'(bc_msg_out), 64'({1'b0, 10'd8, 4'h1, 32'h000000AA}));
`endif
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Random traffic, including boundaries and a hot word for merging.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         bit en, wen, rdy, rst;
         case ($urandom_range(0, 7))
            0: a = START + 32'($urandom_range(0, RS - 1));
            1: a = START + RS + 32'($urandom_range(0, RS - 1));
            2: a = START - 32'($urandom_range(1, 16));
            3: a = START + 2 * RS + 32'($urandom_range(0, 16));
            4: a = 32'($urandom_range(0, 32'h1FFFFFF));
            5: a = START + RS - 32'($urandom_range(1, 4));
            default: a = START + 32'(4 * $urandom_range(0, 2));
         endcase
         en  = ($urandom_range(0, 3) != 0);
         wen = ($urandom_range(0, 4) != 0);
         rdy = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 999) == 0);
         cycle(rst, en, wen, 4'($urandom_range(1, 15)), 25'(a), $urandom, rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
